line_buffer: RTL

//  Multi-row line buffer feeding the 2-D stream filter: holds ROWS-1 image rows and presents a

---
 rtl/line_buffer_if.sv | 28 ++
 rtl/line_buffer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/line_buffer_if.sv
// Stream-side bundle of the line buffer: configuration strobe, upstream pixel
// handshake and downstream column handshake.
interface line_buffer_if #(
   parameter int IMG_WIDTH  = 8,
   parameter int MEM_AWIDTH = 12,
   parameter int ROWS       = 3
);
   logic [MEM_AWIDTH-1:0]     cfg_delay;
   logic                      cfg_pad;
   logic                      cfg_set;
   logic [IMG_WIDTH-1:0]      up_data;
   logic                      up_val;
   logic                      up_rdy;
   logic [ROWS*IMG_WIDTH-1:0] dn_data;
   logic                      dn_eol;
   logic                      dn_val;
   logic                      dn_rdy;

   modport master (
      output cfg_delay, cfg_pad, cfg_set, up_data, up_val, dn_rdy,
      input  up_rdy, dn_data, dn_eol, dn_val
   );

   modport slave (
      input  cfg_delay, cfg_pad, cfg_set, up_data, up_val, dn_rdy,
      output up_rdy, dn_data, dn_eol, dn_val
   );
endinterface

// File: rtl/line_buffer.sv
// Multi-row line buffer: stores ROWS-1 image rows and emits one vertically
// aligned column of ROWS pixels per accepted pixel, with valid/ready on both sides.
module line_buffer #(
   parameter int IMG_WIDTH  = 8,
   parameter int MEM_AWIDTH = 12,
   parameter int MEM_DEPTH  = 1 << MEM_AWIDTH,
   parameter int ROWS       = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   line_buffer_if.slave lb
);

   localparam int NM  = ROWS - 1;
   localparam int RSW = $clog2(ROWS);
   localparam int CW  = ROWS * IMG_WIDTH;

   typedef logic [MEM_AWIDTH-1:0] addr_t;

   logic [IMG_WIDTH-1:0] mem_q [NM][MEM_DEPTH];
   logic [IMG_WIDTH-1:0] tap   [NM];

   addr_t          ptr_q, ptr_d;
   addr_t          lenm1_q, lenm1_d;
   logic [RSW-1:0] rows_q, rows_d;
   logic           pad_q, pad_d;
   logic           busy_q, busy_d;
   logic [CW-1:0]  dn_data_q, dn_data_d;
   logic           dn_val_q, dn_val_d;
   logic           dn_eol_q, dn_eol_d;

   logic up_rdy;
   logic acc;
   logic wrap;
   logic primed;

   // Row length is kept as len-1 so a zero cfg_delay wraps naturally to MEM_DEPTH-1.
   assign up_rdy = !busy_q && !lb.cfg_set && (!dn_val_q || lb.dn_rdy);
   assign acc    = lb.up_val && up_rdy;
   assign wrap   = (ptr_q == lenm1_q);
   assign primed = (rows_q == RSW'(ROWS - 1));

   always_comb begin
      for (int k = 0; k < NM; k++) begin
         tap[k] = mem_q[k][ptr_q];
      end
   end

   always_comb begin
      ptr_d     = ptr_q;
      lenm1_d   = lenm1_q;
      rows_d    = rows_q;
      pad_d     = pad_q;
      busy_d    = lb.cfg_set;
      dn_data_d = dn_data_q;
      dn_val_d  = dn_val_q;
      dn_eol_d  = dn_eol_q;

      if (lb.cfg_set) begin
         lenm1_d = lb.cfg_delay - addr_t'(1);
         pad_d   = lb.cfg_pad;
      end

      if (busy_q) begin
         ptr_d    = '0;
         rows_d   = '0;
         dn_val_d = 1'b0;
      end else if (acc) begin
         ptr_d = wrap ? '0 : ptr_q + addr_t'(1);
         if (wrap && !primed) begin
            rows_d = rows_q + RSW'(1);
         end
         // Taps from rows not yet seen since restart are forced to zero.
         dn_data_d[IMG_WIDTH-1:0] = lb.up_data;
         for (int k = 0; k < NM; k++) begin
            dn_data_d[(k+1)*IMG_WIDTH +: IMG_WIDTH] = (int'(rows_q) > k) ? tap[k] : '0;
         end
         dn_eol_d = wrap;
         dn_val_d = pad_q || primed;
      end else if (lb.dn_rdy) begin
         dn_val_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         lenm1_q   <= '1;
         rows_q    <= '0;
         pad_q     <= 1'b0;
         busy_q    <= 1'b0;
         dn_data_q <= '0;
         dn_val_q  <= 1'b0;
         dn_eol_q  <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         lenm1_q   <= lenm1_d;
         rows_q    <= rows_d;
         pad_q     <= pad_d;
         busy_q    <= busy_d;
         dn_data_q <= dn_data_d;
         dn_val_q  <= dn_val_d;
         dn_eol_q  <= dn_eol_d;
      end
   end

   // Row memories shift one row deeper per accept; contents are never reset.
   always_ff @(posedge clk) begin
      if (acc) begin
         mem_q[0][ptr_q] <= lb.up_data;
         for (int k = 1; k < NM; k++) begin
            mem_q[k][ptr_q] <= tap[k-1];
         end
      end
   end

   assign lb.up_rdy  = up_rdy;
   assign lb.dn_data = dn_data_q;
   assign lb.dn_val  = dn_val_q;
   assign lb.dn_eol  = dn_eol_q;

endmodule
